// File: rtl/fft_peak_detect.sv
// FFT peak detector: collects one 8-bin FFT frame from the slave, computes
// per-bin magnitude squared, and presents the peak bin, peak magnitude,
// total energy and a threshold flag once the whole frame has arrived.
module fft_peak_detect #(
   parameter logic [31:0] THRESH = 32'd1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        ack,
   input  logic [31:0] fft_data,
   output logic [2:0]  peak_bin,
   output logic [31:0] peak_mag,
   output logic [34:0] energy,
   output logic        above_thr,
   output logic        done,
   output logic        frame_err
);

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, WAIT_LOW} state_t;

   state_t      state_q, state_d;
   logic [2:0]  binCnt_q, binCnt_d;
   logic        accept;
   logic        frameErr_q, frameErr_d;

   logic signed [15:0] reIn, imIn;
   logic signed [31:0] reSq, imSq;
   logic [31:0]        magNow;

   logic        s1Valid_q;
   logic [31:0] s1Mag_q;
   logic [2:0]  s1Bin_q;

   logic [31:0] runPeakMag_q, runPeakMag_d;
   logic [2:0]  runPeakBin_q, runPeakBin_d;
   logic [34:0] runEnergy_q, runEnergy_d;

   logic [2:0]  peakBin_q;
   logic [31:0] peakMag_q;
   logic [34:0] energy_q;
   logic        aboveThr_q;
   logic        done_q;

   // Frame sequencing: decides which ack cycles carry an accepted bin and
   // flags frames that stop before bin 7.
   always_comb begin
      state_d    = state_q;
      binCnt_d   = binCnt_q;
      accept     = 1'b0;
      frameErr_d = 1'b0;
      case (state_q)
         IDLE: begin
            binCnt_d = 3'd0;
            if (ack && en) begin
               accept   = 1'b1;
               binCnt_d = 3'd1;
               state_d  = COLLECT;
            end else if (ack) begin
               state_d = WAIT_LOW;
            end
         end
         COLLECT: begin
            if (ack) begin
               accept = 1'b1;
               if (binCnt_q == 3'd7) begin
                  binCnt_d = 3'd0;
                  state_d  = DRAIN;
               end else begin
                  binCnt_d = binCnt_q + 3'd1;
               end
            end else begin
               frameErr_d = 1'b1;
               binCnt_d   = 3'd0;
               state_d    = IDLE;
            end
         end
         DRAIN: begin
            state_d = ack ? WAIT_LOW : IDLE;
         end
         WAIT_LOW: begin
            if (!ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, bin counter and error pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         binCnt_q   <= 3'd0;
         frameErr_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         binCnt_q   <= binCnt_d;
         frameErr_q <= frameErr_d;
      end
   end

   // Magnitude squared of the incoming bin; each square is at most 2^30 so
   // the sum always fits in 32 unsigned bits.
   always_comb begin
      reIn   = fft_data[31:16];
      imIn   = fft_data[15:0];
      reSq   = reIn * reIn;
      imSq   = imIn * imIn;
      magNow = $unsigned(reSq) + $unsigned(imSq);
   end

   // Stage 1: capture magnitude and bin index on the accept edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1Valid_q <= 1'b0;
         s1Mag_q   <= 32'd0;
         s1Bin_q   <= 3'd0;
      end else begin
         s1Valid_q <= accept;
         if (accept) begin
            s1Mag_q <= magNow;
            s1Bin_q <= binCnt_q;
         end
      end
   end

   // Running peak and energy; bin 0 restarts both, later bins only replace
   // the peak when strictly larger so ties keep the lowest bin.
   always_comb begin
      runPeakMag_d = runPeakMag_q;
      runPeakBin_d = runPeakBin_q;
      runEnergy_d  = runEnergy_q;
      if (s1Bin_q == 3'd0) begin
         runPeakMag_d = s1Mag_q;
         runPeakBin_d = 3'd0;
         runEnergy_d  = {3'b000, s1Mag_q};
      end else begin
         runEnergy_d = runEnergy_q + {3'b000, s1Mag_q};
         if (s1Mag_q > runPeakMag_q) begin
            runPeakMag_d = s1Mag_q;
            runPeakBin_d = s1Bin_q;
         end
      end
   end

   // Stage 2: update running values and publish results when bin 7 lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         runPeakMag_q <= 32'd0;
         runPeakBin_q <= 3'd0;
         runEnergy_q  <= 35'd0;
         peakBin_q    <= 3'd0;
         peakMag_q    <= 32'd0;
         energy_q     <= 35'd0;
         aboveThr_q   <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (s1Valid_q) begin
            runPeakMag_q <= runPeakMag_d;
            runPeakBin_q <= runPeakBin_d;
            runEnergy_q  <= runEnergy_d;
            if (s1Bin_q == 3'd7) begin
               peakBin_q  <= runPeakBin_d;
               peakMag_q  <= runPeakMag_d;
               energy_q   <= runEnergy_d;
               aboveThr_q <= (runPeakMag_d > THRESH);
               done_q     <= 1'b1;
            end
         end
      end
   end

   assign peak_bin  = peakBin_q;
   assign peak_mag  = peakMag_q;
   assign energy    = energy_q;
   assign above_thr = aboveThr_q;
   assign done      = done_q;
   assign frame_err = frameErr_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Testbench for fft_peak_detect: drives fixed and random frames, predicts
// results from a plain arithmetic model and checks them in a monitor.
module tb_fft_peak_detect;

   localparam longint THRESH = 1000000;

   typedef struct packed {
      logic [2:0]  bin;
      logic [31:0] mag;
      logic [34:0] energy;
      logic        above;
   } res_t;

   logic        clk;
   logic        rst;
   logic        en;
   logic        ack;
   logic [31:0] fft_data;
   logic [2:0]  peak_bin;
   logic [31:0] peak_mag;
   logic [34:0] energy;
   logic        above_thr;
   logic        done;
   logic        frame_err;

   int checks   = 0;
   int failures = 0;

   res_t sbQ[$];
   res_t lastExp;
   int   expErrPending = 0;

   int frameRe[8];
   int frameIm[8];

   fft_peak_detect #(.THRESH(32'd1000000)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .ack       (ack),
      .fft_data  (fft_data),
      .peak_bin  (peak_bin),
      .peak_mag  (peak_mag),
      .energy    (energy),
      .above_thr (above_thr),
      .done      (done),
      .frame_err (frame_err)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Reference result of a full frame from the current bin arrays.
   function automatic res_t computeExpected();
      longint mags[8];
      longint total;
      int     best;
      res_t   r;
      total = 0;
      best  = 0;
      for (int i = 0; i < 8; i++) begin
         mags[i] = longint'(frameRe[i]) * frameRe[i] + longint'(frameIm[i]) * frameIm[i];
         total  += mags[i];
      end
      for (int i = 1; i < 8; i++)
         if (mags[i] > mags[best]) best = i;
      r.bin    = 3'(best);
      r.mag    = 32'(mags[best]);
      r.energy = 35'(total);
      r.above  = (mags[best] > THRESH);
      return r;
   endfunction

   // Drive one frame of nAcks consecutive ack cycles, then idle cycles.
   task automatic applyStimulus(input bit enV, input int nAcks);
      if (enV && nAcks >= 8) sbQ.push_back(computeExpected());
      else if (enV && nAcks > 0) expErrPending++;
      for (int i = 0; i < nAcks; i++) begin
         @(posedge clk); #1;
         en       = enV;
         ack      = 1'b1;
         fft_data = {16'(frameRe[i % 8]), 16'(frameIm[i % 8])};
      end
      @(posedge clk); #1;
      ack      = 1'b0;
      en       = 1'b0;
      fft_data = $urandom;
      repeat (6) @(posedge clk);
   endtask

   task automatic setAllBins(input int re, input int im);
      for (int i = 0; i < 8; i++) begin
         frameRe[i] = re;
         frameIm[i] = im;
      end
   endtask

   task automatic randomBins();
      int smallVals[4] = '{0, 5, -5, 3};
      for (int i = 0; i < 8; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            frameRe[i] = smallVals[$urandom_range(0, 3)];
            frameIm[i] = smallVals[$urandom_range(0, 3)];
         end else begin
            frameRe[i] = int'($signed(16'($urandom)));
            frameIm[i] = int'($signed(16'($urandom)));
         end
      end
   endtask

   task automatic checkZeroOutputs(input string tag);
      checkOutput({tag, "_peak_bin"}, 64'(peak_bin), 64'd0);
      checkOutput({tag, "_peak_mag"}, 64'(peak_mag), 64'd0);
      checkOutput({tag, "_energy"}, 64'(energy), 64'd0);
      checkOutput({tag, "_above_thr"}, 64'(above_thr), 64'd0);
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_frame_err"}, 64'(frame_err), 64'd0);
   endtask

   // Monitor: pops expected results on done, accounts for error pulses and
   // checks that published outputs hold between results.
   initial begin
      res_t got;
      lastExp = '0;
      forever begin
         @(negedge clk);
         if (rst) lastExp = '0;
         if (done && frame_err) begin
            checks++;
            failures++;
            $display("[TB] FAIL pulse_overlap: done=%0b frame_err=%0b expected not both", done, frame_err);
         end
         if (done) begin
            if (sbQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
               lastExp = sbQ.pop_front();
            end
         end
         if (frame_err) begin
            checks++;
            if (expErrPending > 0) begin
               expErrPending--;
            end else begin
               failures++;
               $display("[TB] FAIL unexpected_frame_err: got frame_err=1 expected 0");
            end
         end
         got = '{bin: peak_bin, mag: peak_mag, energy: energy, above: above_thr};
         checkOutput("result_outputs", 64'(got), 64'(lastExp));
      end
   end

   // Main stimulus sequence.
   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      ack      = 1'b0;
      fft_data = 32'd0;
      repeat (2) @(posedge clk); #1;
      checkZeroOutputs("reset");
      rst = 1'b0;
      repeat (3) @(posedge clk);

      $display("[TB] single bin peak");
      setAllBins(0, 0);
      frameRe[3] = 100;
      applyStimulus(1'b1, 8);

      $display("[TB] tie between bins 2 and 5");
      setAllBins(1, 1);
      frameIm[2] = -3000;
      frameRe[2] = 0;
      frameIm[5] = -3000;
      frameRe[5] = 0;
      applyStimulus(1'b1, 8);

      $display("[TB] full-scale negative bins");
      setAllBins(-32768, -32768);
      applyStimulus(1'b1, 8);

      $display("[TB] aborted frame then recovery");
      randomBins();
      applyStimulus(1'b1, 5);
      randomBins();
      applyStimulus(1'b1, 8);

      $display("[TB] disabled frame and nine acks");
      randomBins();
      applyStimulus(1'b0, 8);
      randomBins();
      applyStimulus(1'b1, 9);

      $display("[TB] reset mid-frame");
      randomBins();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         en       = 1'b1;
         ack      = 1'b1;
         fft_data = {16'(frameRe[i]), 16'(frameIm[i])};
      end
      @(posedge clk); #1;
      rst = 1'b1;
      ack = 1'b0;
      en  = 1'b0;
      #1;
      checkZeroOutputs("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      randomBins();
      applyStimulus(1'b1, 8);

      $display("[TB] random frames");
      for (int n = 0; n < 25; n++) begin
         randomBins();
         case ($urandom_range(0, 5))
            0:       applyStimulus(1'b1, $urandom_range(1, 7));
            1:       applyStimulus(1'b0, 8);
            2:       applyStimulus(1'b1, 9);
            default: applyStimulus(1'b1, 8);
         endcase
      end

      repeat (10) @(posedge clk);
      checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);
      checkOutput("frame_err_pending", 64'(expErrPending), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter THRESH, default 32'd1000000, unsigned magnitude-squared threshold for above_thr.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port en, input, 1, frame capture enable, sampled only in IDLE.
REQ-005 SHALL have port ack, input, 1, FFT slave output-valid strobe; one bin per high cycle.
REQ-006 SHALL have port fft_data, input, 32, bin word; [31:16] signed real, [15:0] signed imaginary.
REQ-007 SHALL have port peak_bin, output, 3, index of largest-magnitude bin of last good frame.
REQ-008 SHALL have port peak_mag, output, 32, unsigned re^2+im^2 of peak bin.
REQ-009 SHALL have port energy, output, 35, unsigned sum of all 8 bin magnitudes.
REQ-010 SHALL have port above_thr, output, 1, peak_mag > THRESH.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when new results are presented.
REQ-012 SHALL have port frame_err, output, 1, one-cycle pulse on aborted frame.

Function
REQ-013 SHALL implement FSM states IDLE, COLLECT, DRAIN, WAIT_LOW.
REQ-014 IDLE: ack=1 with en=1 SHALL accept bin 0 and go to COLLECT; ack=1 with en=0 SHALL go to WAIT_LOW, nothing accepted.
REQ-015 COLLECT: each ack=1 cycle SHALL accept next bin, bin index incrementing 0..7; acceptance of bin 7 SHALL go to DRAIN.
REQ-016 COLLECT: ack=0 before bin 7 SHALL pulse frame_err next cycle, discard partial frame, return to IDLE; result outputs unchanged.
REQ-017 DRAIN SHALL last one cycle, then go to WAIT_LOW if ack=1 else IDLE.
REQ-018 WAIT_LOW SHALL ignore all data until ack=0, then go to IDLE.
REQ-019 Stage 1 SHALL register mag = re*re + im*im (signed 16x16 products, 32-bit unsigned sum, no overflow; max 2^31) plus bin index at the accept edge.
REQ-020 Stage 2 SHALL, one edge later, add mag to 35-bit running energy and replace running peak only if mag strictly greater (ties keep lowest bin); bin 0 initialises peak and energy.
REQ-021 Stage 2 processing of bin 7 SHALL load peak_bin, peak_mag, energy, above_thr and set done=1 on the same edge; latency = 2 clk edges from bin-7 accept edge.
REQ-022 done and frame_err SHALL each be high for exactly one cycle and never together.
REQ-023 Result outputs SHALL hold until next done; partial-frame running values SHALL never appear on outputs.
REQ-024 A new frame whose bin 0 arrives during DRAIN SHALL NOT be accepted (slave guarantees >=4 idle cycles between frames).

Reset
REQ-025 rst SHALL immediately force IDLE, bin counter 0, pipeline valid 0, peak_bin 0, peak_mag 0, energy 0, above_thr 0, done 0, frame_err 0.
REQ-026 rst during COLLECT or DRAIN SHALL discard the frame with no done or frame_err pulse.

Verification
REQ-027 en=1, 8 acks, bin3=(100,0), others 0 -> done 2 edges after bin 7; peak_bin=3, peak_mag=10000, energy=10000, above_thr=0.
REQ-028 bins 2 and 5 both (0,-3000), others (1,1) -> peak_bin=2, peak_mag=9000000, energy=18000012, above_thr=1.
REQ-029 all 8 bins (-32768,-32768) -> peak_mag=32'h80000000, peak_bin=0, energy=35'h400000000.
REQ-030 5 acks then ack=0 -> frame_err one pulse, no done, outputs retain prior frame values; next full frame processes normally.
REQ-031 en=0 during full frame -> no done, no frame_err, outputs unchanged; 9 consecutive acks with en=1 -> done once, 9th bin ignored.
REQ-032 rst asserted after bin 4 -> all outputs 0 immediately, no pulses; subsequent frame correct.
